// File: rtl/alu_divider8.sv
// Multi-cycle unsigned restoring divider.
// One quotient bit per cycle; divide-by-zero completes immediately.
module alu_divider8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH:0]   prem;

  logic [WIDTH:0]   shr;
  logic [WIDTH:0]   sub;
  logic             ge;
  logic [WIDTH-1:0] qn;

  // opa shifts dividend bits out and quotient bits in
  always_comb begin
    shr = (prem << 1) | {{WIDTH{1'b0}}, opa[WIDTH-1]};
    ge  = (shr >= {1'b0, opb});
    sub = ge ? (shr - {1'b0, opb}) : shr;
    qn  = {opa[WIDTH-2:0], ge};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      opa         <= '0;
      opb         <= '0;
      prem        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            opa  <= A;
            opb  <= B;
            cnt  <= '0;
            prem <= '0;
            if (B == '0) begin
              state       <= DONE;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= A;
              div_by_zero <= 1'b1;
            end else begin
              state <= CALC;
              busy  <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          opa  <= qn;
          prem <= sub;
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            state       <= DONE;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b1;
            quotient    <= qn;
            remainder   <= sub[WIDTH-1:0];
            div_by_zero <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_divider8.sv
// Directed self-checking bench for alu_divider8.
// Vectors carry hand-computed quotient/remainder values.
module tb_alu_divider8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] A;
  logic [7:0] B;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  int n_cmp = 0;
  int n_bad = 0;

  alu_divider8 #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .A           (A),
    .B           (B),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] a, input logic [7:0] b);
    A     = a;
    B     = b;
    start = 1'b1;
    step();
  endtask

  // Called just after the accepting edge; lat counts edges until done.
  task automatic wait_done(input string tag, input int exp_lat,
                           input int exp_busy, input int q,
                           input int r, input int dz);
    int lat = 0;
    int bc = 0;
    int ov = 0;
    while (!done && lat < 20) begin
      if (busy) bc++;
      if (busy && done) ov++;
      step();
      lat++;
    end
    chk({tag, ".done"}, int'(done), 1);
    chk({tag, ".lat"}, lat, exp_lat);
    chk({tag, ".busycyc"}, bc, exp_busy);
    chk({tag, ".overlap"}, ov + int'(busy), 0);
    chk({tag, ".q"}, int'(quotient), q);
    chk({tag, ".r"}, int'(remainder), r);
    chk({tag, ".dz"}, int'(div_by_zero), dz);
  endtask

  task automatic run(input string tag, input logic [7:0] a,
                     input logic [7:0] b, input int q, input int r,
                     input int dz);
    issue(a, b);
    start = 1'b0;
    A     = 8'hAA;
    B     = 8'h55;
    if (b != 0) wait_done(tag, 8, 8, q, r, dz);
    else        wait_done(tag, 0, 0, q, r, dz);
    step();
    chk({tag, ".pulse"}, int'(done), 0);
  endtask

  initial begin
    int dcnt;
    rst_n = 1'b0;
    start = 1'b0;
    A     = '0;
    B     = '0;
    #12;
    chk("rst.busy", int'(busy), 0);
    chk("rst.done", int'(done), 0);
    chk("rst.q", int'(quotient), 0);
    chk("rst.r", int'(remainder), 0);
    chk("rst.dz", int'(div_by_zero), 0);
    step();
    rst_n = 1'b1;

    run("d200_7", 8'd200, 8'd7, 28, 4, 0);
    run("d255_1", 8'd255, 8'd1, 255, 0, 0);
    run("d255_128", 8'd255, 8'd128, 1, 127, 0);

    // Reset in the middle of a division
    issue(8'd200, 8'd7);
    start = 1'b0;
    repeat (4) step();
    chk("mid.busy", int'(busy), 1);
    chk("mid.qhold", int'(quotient), 1);
    chk("mid.rhold", int'(remainder), 127);
    rst_n = 1'b0;
    #1;
    chk("arst.busy", int'(busy), 0);
    chk("arst.q", int'(quotient), 0);
    chk("arst.r", int'(remainder), 0);
    dcnt = 0;
    repeat (3) begin
      step();
      dcnt += int'(done) + int'(busy);
    end
    chk("arst.quiet", dcnt, 0);
    rst_n = 1'b1;
    run("rerun200_7", 8'd200, 8'd7, 28, 4, 0);

    run("d5_0", 8'd5, 8'd0, 255, 5, 1);
    run("d9_3", 8'd9, 8'd3, 3, 0, 0);

    // Start pulsed during CALC must be ignored
    issue(8'd3, 8'd10);
    start = 1'b0;
    repeat (3) step();
    chk("ign.qhold", int'(quotient), 3);
    chk("ign.dzhold", int'(div_by_zero), 0);
    issue(8'd100, 8'd9);
    start = 1'b0;
    wait_done("ign", 4, 4, 0, 3, 0);
    dcnt = 0;
    repeat (10) begin
      step();
      dcnt += int'(done) + int'(busy);
    end
    chk("ign.nodone", dcnt, 0);

    // Start held through DONE: back-to-back acceptance
    issue(8'd50, 8'd6);
    wait_done("b2b1", 8, 8, 8, 2, 0);
    step();
    start = 1'b0;
    chk("b2b.busy", int'(busy), 1);
    chk("b2b.done", int'(done), 0);
    wait_done("b2b2", 8, 8, 8, 2, 0);
    step();
    chk("b2b.pulse", int'(done), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
